// File: rtl/arima_pkg.sv
// rtl/arima_pkg.sv - shared constants and state type for the ARIMA MA sequencer
package arima_pkg;
    localparam int N_TAPS          = 10;
    localparam int Q_FRAC          = 15;
    localparam int CFG_ADDR_QORDER = 10;

    localparam logic [1:0] MA_CTRL_SHIFT = 2'b00;
    localparam logic [1:0] MA_CTRL_STALL = 2'b01;
    localparam logic [1:0] MA_CTRL_INIT  = 2'b10;
    localparam logic [1:0] MA_CTRL_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_INIT  = 2'd2,
        ST_RUN   = 2'd3
    } ma_ctrl_state_t;
endpackage

// File: rtl/ma_cfg_regfile.sv
// rtl/ma_cfg_regfile.sv - shadow coefficient/q-order registers with address decode
module ma_cfg_regfile
    import arima_pkg::*;
#(
    parameter int N_TAPS = arima_pkg::N_TAPS,
    parameter int DW     = 32,
    parameter int QW     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [3:0]                   addr,
    input  logic [DW-1:0]                wdata,
    output logic [N_TAPS-1:0][DW-1:0]    coef,
    output logic [QW-1:0]                q_order,
    output logic                         illegal
);
    logic hit_qorder;

    assign hit_qorder = (addr == 4'(CFG_ADDR_QORDER));
    // Anything that is neither a tap nor the q-order slot is flagged and dropped.
    assign illegal    = we && !hit_qorder && (addr >= 4'(N_TAPS));

    always_ff @(posedge clk) begin
        if (rst) begin
            coef    <= '0;
            q_order <= '0;
        end else if (we) begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (addr == 4'(i)) coef[i] <= wdata;
            end
            if (hit_qorder) q_order <= QW'(wdata);
        end
    end
endmodule

// File: rtl/ma_seq_ctrl.sv
// rtl/ma_seq_ctrl.sv - MA datapath sequencer with valid/ready stream wrapper
module ma_seq_ctrl
    import arima_pkg::*;
#(
    parameter int N_TAPS = arima_pkg::N_TAPS,
    parameter int DW     = 32,
    parameter int QW     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [3:0]                   cfg_addr,
    input  logic [DW-1:0]                cfg_wdata,
    input  logic                         start,
    input  logic                         flush,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DW-1:0]                s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DW-1:0]                m_data,
    output logic [1:0]                   ma_control,
    output logic [N_TAPS-1:0][DW-1:0]    ma_coef_out,
    output logic [QW-1:0]                ma_q_order_out,
    output logic [DW-1:0]                ma_data_in,
    input  logic [DW-1:0]                ma_data_out,
    output logic                         busy,
    output logic                         err
);
    ma_ctrl_state_t state;
    logic [3:0]     fill_cnt;
    logic           cfg_take;
    logic           cfg_illegal;
    logic           q_ok;
    logic           shift;

    // Config writes only land in a quiet IDLE cycle; start or flush take precedence.
    assign cfg_take = (state == ST_IDLE) && cfg_we && !start && !flush;
    assign q_ok     = (ma_q_order_out != '0) && (ma_q_order_out <= QW'(N_TAPS));

    ma_cfg_regfile #(.N_TAPS(N_TAPS), .DW(DW), .QW(QW)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_take),
        .addr    (cfg_addr),
        .wdata   (cfg_wdata),
        .coef    (ma_coef_out),
        .q_order (ma_q_order_out),
        .illegal (cfg_illegal)
    );

    assign s_ready    = (state == ST_RUN) && (!m_valid || m_ready);
    assign shift      = s_ready && s_valid;
    assign busy       = (state != ST_IDLE);
    assign ma_data_in = s_data;
    assign m_data     = ma_data_out;

    always_comb begin
        ma_control = MA_CTRL_CLEAR;
        case (state)
            ST_RESET: ma_control = MA_CTRL_CLEAR;
            ST_IDLE:  ma_control = MA_CTRL_STALL;
            ST_INIT:  ma_control = MA_CTRL_INIT;
            ST_RUN:   ma_control = shift ? MA_CTRL_SHIFT : MA_CTRL_STALL;
            default:  ma_control = MA_CTRL_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RESET;
            m_valid  <= 1'b0;
            err      <= 1'b0;
            fill_cnt <= '0;
        end else if (flush && state != ST_RESET) begin
            state   <= ST_RESET;
            m_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_RESET: state <= ST_IDLE;
                ST_IDLE: begin
                    if (start) begin
                        if (q_ok) state <= ST_INIT;
                        else      err   <= 1'b1;
                    end else if (cfg_illegal) begin
                        err <= 1'b1;
                    end
                end
                ST_INIT: begin
                    fill_cnt <= '0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    // Warm-up: outputs stay suppressed until q_order samples are in the window.
                    if (shift) begin
                        if (QW'(fill_cnt) < ma_q_order_out) fill_cnt <= fill_cnt + 4'd1;
                        m_valid <= (QW'(fill_cnt) + QW'(1)) >= ma_q_order_out;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_ma_seq_ctrl.sv
// tb/tb_ma_seq_ctrl.sv - directed self-checking bench for ma_seq_ctrl
module tb_ma_seq_ctrl;
    localparam int NT = 10;
    localparam int DW = 32;
    localparam int QW = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cfg_we;
    logic [3:0]               cfg_addr;
    logic [DW-1:0]            cfg_wdata;
    logic                     start;
    logic                     flush;
    logic                     s_valid;
    logic                     s_ready;
    logic [DW-1:0]            s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [DW-1:0]            m_data;
    logic [1:0]               ma_control;
    logic [NT-1:0][DW-1:0]    ma_coef_out;
    logic [QW-1:0]            ma_q_order_out;
    logic [DW-1:0]            ma_data_in;
    logic [DW-1:0]            ma_data_out;
    logic                     busy;
    logic                     err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ma_seq_ctrl #(.N_TAPS(NT), .DW(DW), .QW(QW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .start          (start),
        .flush          (flush),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .ma_control     (ma_control),
        .ma_coef_out    (ma_coef_out),
        .ma_q_order_out (ma_q_order_out),
        .ma_data_in     (ma_data_in),
        .ma_data_out    (ma_data_out),
        .busy           (busy),
        .err            (err)
    );

    // Behavioural MA datapath: Q15 FIR over the last q samples, registered output.
    logic signed [DW-1:0] win [NT];
    logic signed [DW-1:0] lc  [NT];
    int                   lq;
    logic [DW-1:0]        y;
    assign ma_data_out = y;

    always @(posedge clk) begin
        longint acc;
        case (ma_control)
            2'b11: begin
                for (int i = 0; i < NT; i++) win[i] <= '0;
                y <= '0;
            end
            2'b10: begin
                for (int i = 0; i < NT; i++) begin
                    win[i] <= '0;
                    lc[i]  <= ma_coef_out[i];
                end
                lq <= int'(ma_q_order_out);
            end
            2'b00: begin
                acc = longint'($signed(ma_data_in)) * longint'(lc[0]);
                for (int k = 1; k < NT; k++)
                    if (k < lq) acc += longint'(win[k-1]) * longint'(lc[k]);
                for (int i = NT - 1; i > 0; i--) win[i] <= win[i-1];
                win[0] <= $signed(ma_data_in);
                y <= DW'(acc >>> 15);
            end
            default: ;
        endcase
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
        flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        y = '0; lq = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        expect_eq("rst_ctrl_clear", ma_control, 2'b11);
        expect_eq("rst_busy", busy, 1'b1);
        expect_eq("rst_mvalid", m_valid, 1'b0);
        expect_eq("rst_err", err, 1'b0);
        expect_eq("rst_sready", s_ready, 1'b0);
        step();
        expect_eq("idle_ctrl", ma_control, 2'b01);
        expect_eq("idle_busy", busy, 1'b0);

        // Fill and filter
        cfg_write(4'd0, 32'h8000);
        cfg_write(4'd1, 32'h4000);
        cfg_write(4'd2, 32'h2000);
        cfg_write(4'd10, 32'd3);
        start = 1'b1; step(); start = 1'b0;
        expect_eq("init_ctrl", ma_control, 2'b10);
        step();
        s_valid = 1'b1; s_data = 32'h8000; m_ready = 1'b1;
        #1;
        expect_eq("run_sready", s_ready, 1'b1);
        expect_eq("run_ctrl_shift", ma_control, 2'b00);
        expect_eq("data_in_pass", ma_data_in, 32'h8000);
        step();
        expect_eq("warm1_mvalid", m_valid, 1'b0);
        step();
        expect_eq("warm2_mvalid", m_valid, 1'b0);
        step();
        expect_eq("s3_mvalid", m_valid, 1'b1);
        expect_eq("s3_mdata", m_data, 32'hE000);
        s_data = 32'h0;
        step();
        expect_eq("s4_mvalid", m_valid, 1'b1);
        expect_eq("s4_mdata", m_data, 32'h6000);
        s_valid = 1'b0;
        step();
        expect_eq("drain_mvalid", m_valid, 1'b0);

        // Backpressure
        s_valid = 1'b1; s_data = 32'h8000; m_ready = 1'b0;
        step();
        expect_eq("bp_mvalid", m_valid, 1'b1);
        expect_eq("bp_sready", s_ready, 1'b0);
        expect_eq("bp_ctrl_stall", ma_control, 2'b01);
        expect_eq("bp_mdata", m_data, 32'hA000);
        step();
        expect_eq("bp_hold_mvalid", m_valid, 1'b1);
        expect_eq("bp_hold_mdata", m_data, 32'hA000);
        s_data = 32'h0; m_ready = 1'b1;
        #1;
        expect_eq("bp_release_sready", s_ready, 1'b1);
        expect_eq("bp_release_ctrl", ma_control, 2'b00);
        step();
        expect_eq("bp_next_mvalid", m_valid, 1'b1);
        expect_eq("bp_next_mdata", m_data, 32'h4000);

        // Flush mid-RUN with m_valid=1, then rerun with retained coefficients
        s_valid = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        expect_eq("fl_mvalid", m_valid, 1'b0);
        expect_eq("fl_ctrl_clear", ma_control, 2'b11);
        step();
        expect_eq("fl_idle_ctrl", ma_control, 2'b01);
        expect_eq("fl_idle_busy", busy, 1'b0);
        expect_eq("fl_coef_kept", ma_coef_out[1], 32'h4000);
        start = 1'b1; step(); start = 1'b0;
        step();
        s_valid = 1'b1; s_data = 32'h4000; m_ready = 1'b1;
        step();
        expect_eq("re_warm1", m_valid, 1'b0);
        step();
        expect_eq("re_warm2", m_valid, 1'b0);
        step();
        expect_eq("re_s3_mvalid", m_valid, 1'b1);
        expect_eq("re_s3_mdata", m_data, 32'h7000);
        s_valid = 1'b0;
        do_flush();

        // Config errors
        cfg_write(4'd10, 32'd0);
        start = 1'b1; step(); start = 1'b0;
        expect_eq("q0_err", err, 1'b1);
        expect_eq("q0_idle", busy, 1'b0);
        expect_eq("q0_ctrl", ma_control, 2'b01);
        do_flush();
        expect_eq("q0_err_cleared", err, 1'b0);
        cfg_write(4'd10, 32'd11);
        start = 1'b1; step(); start = 1'b0;
        expect_eq("q11_err", err, 1'b1);
        expect_eq("q11_idle", busy, 1'b0);
        do_flush();
        cfg_write(4'd12, 32'h1234);
        expect_eq("addr12_err", err, 1'b1);
        expect_eq("addr12_q_kept", ma_q_order_out, 32'd11);
        expect_eq("addr12_c2_kept", ma_coef_out[2], 32'h2000);
        do_flush();
        expect_eq("addr12_err_cleared", err, 1'b0);

        // Simultaneous events
        cfg_write(4'd10, 32'd3);
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd10; cfg_wdata = 32'd5;
        step();
        start = 1'b0; cfg_we = 1'b0;
        expect_eq("sim_init", ma_control, 2'b10);
        expect_eq("sim_write_ignored", ma_q_order_out, 32'd3);
        step();
        do_flush();
        flush = 1'b1; start = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        expect_eq("fl_start_reset", ma_control, 2'b11);
        expect_eq("fl_start_busy", busy, 1'b1);
        step();
        expect_eq("fl_start_idle", ma_control, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
